// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// Bit timing uses the same ticks-per-bit model as the companion receiver.
module uart_tx #(
    parameter int unsigned TICKS_PER_BIT      = 32,
    parameter int unsigned TICKS_PER_BIT_SIZE = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [7:0] i_txdata,
    input  logic       i_send,
    output logic       o_dout,
    output logic       o_done,
    output logic       o_busy
);

    localparam int unsigned TW = TICKS_PER_BIT_SIZE;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        SEND_START = 5'b00010,
        SEND_DATA  = 5'b00100,
        SEND_STOP  = 5'b01000,
        DONE       = 5'b10000
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_end;

    assign bit_end = (tick == TICK_LAST);

    // Frame sequencer; every output is registered so the line never glitches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            o_dout  <= 1'b1;
            o_done  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    tick   <= '0;
                    o_dout <= 1'b1;
                    o_busy <= 1'b0;
                    if (i_enable && i_send) begin
                        shift   <= i_txdata;
                        bit_cnt <= '0;
                        state   <= SEND_START;
                        o_dout  <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                SEND_START: begin
                    if (bit_end) begin
                        tick   <= '0;
                        state  <= SEND_DATA;
                        o_dout <= shift[0];
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                SEND_DATA: begin
                    if (bit_end) begin
                        tick    <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        // Line shows the next bit as soon as the shift happens.
                        if (bit_cnt == 4'd7) begin
                            state  <= SEND_STOP;
                            o_dout <= 1'b1;
                        end else begin
                            o_dout <= shift[1];
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                SEND_STOP: begin
                    if (bit_end) begin
                        tick   <= '0;
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_dout <= 1'b1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                DONE: begin
                    tick   <= '0;
                    state  <= IDLE;
                    o_dout <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                    o_dout  <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timeline model checked every cycle, line decoder,
// and literal expectations at hand-computed cycle offsets.
module tb_uart_tx;

    localparam int unsigned T     = 32;
    localparam int unsigned FRAME = 10 * T;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_enable;
    logic [7:0] i_txdata;
    logic       i_send;
    logic       o_dout;
    logic       o_done;
    logic       o_busy;

    always #5 clk = ~clk;

    uart_tx #(.TICKS_PER_BIT(T), .TICKS_PER_BIT_SIZE(6)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_enable(i_enable),
        .i_txdata(i_txdata),
        .i_send  (i_send),
        .o_dout  (o_dout),
        .o_done  (o_done),
        .o_busy  (o_busy)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: remembers the accept cycle and byte; outputs follow from the offset.
    int unsigned cyc      = 0;
    logic        m_valid  = 1'b0;
    logic        m_active = 1'b0;
    int unsigned m_n      = 0;
    logic [7:0]  m_byte   = 8'h00;

    always @(posedge clk) begin
        if (i_rst) begin
            m_active <= 1'b0;
            m_valid  <= 1'b1;
        end else if (!m_active && i_enable && i_send) begin
            m_active <= 1'b1;
            m_n      <= cyc;
            m_byte   <= i_txdata;
        end else if (m_active && cyc == m_n + FRAME + 1) begin
            m_active <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    function automatic logic exp_line(int unsigned d, logic [7:0] b);
        if (d <= T) return 1'b0;
        if (d <= 9 * T) return b[3'((d - 1) / T - 1)];
        return 1'b1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Line decoder state
    logic        rx_busy = 1'b0;
    int unsigned rx_t    = 0;
    logic [7:0]  rx_sh   = 8'h00;
    logic [7:0]  rxq[$];
    int unsigned done_cnt = 0;

    task automatic tick();
        int unsigned d;
        logic        e_dout;
        logic        e_done;
        @(negedge clk);
        if (m_valid) begin
            d      = cyc - m_n;
            e_dout = m_active ? exp_line(d, m_byte) : 1'b1;
            e_done = m_active && (d == FRAME + 1);
            check("model_dout", 32'(o_dout), 32'(e_dout));
            check("model_busy", 32'(o_busy), 32'(m_active));
            check("model_done", 32'(o_done), 32'(e_done));
            if (o_done) done_cnt++;
            if (!rx_busy) begin
                if (o_dout == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_t    = 0;
                end
            end else begin
                rx_t++;
                if (rx_t == 9 * T + T / 2) begin
                    check("rx_stop", 32'(o_dout), 32'd1);
                    rxq.push_back(rx_sh);
                    rx_busy = 1'b0;
                end else if (rx_t >= T + T / 2 && (rx_t - T / 2) % T == 0) begin
                    rx_sh = {o_dout, rx_sh[7:1]};
                end
            end
        end
    endtask

    task automatic wait_to(int unsigned target);
        while (cyc < target) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (!o_busy && !rx_busy) break;
            tick();
        end
        check("idle_timeout", 32'(o_busy | rx_busy), 32'd0);
    endtask

    task automatic send_byte(logic [7:0] b, output int unsigned n);
        i_txdata = b;
        i_send   = 1'b1;
        n        = cyc;
        tick();
        i_send   = 1'b0;
    endtask

    task automatic expect_rx(string name, logic [7:0] b);
        if (rxq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s at cycle %0d: got no byte expected %0h", name, cyc, b);
        end else begin
            check(name, 32'(rxq.pop_front()), 32'(b));
        end
    endtask

    logic [7:0] lb_bytes[4] = '{8'h00, 8'hFF, 8'h55, 8'h80};
    logic       a5_bits[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int unsigned n;
        int unsigned d0;
        i_rst    = 1'b1;
        i_enable = 1'b1;
        i_txdata = 8'h00;
        i_send   = 1'b0;
        tick();
        i_rst = 1'b0;
        check("rst_dout", 32'(o_dout), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        repeat (3) tick();

        // Single byte 0xA5 with literal timing points
        send_byte(8'hA5, n);
        check("a5_start_first", 32'(o_dout), 32'd0);
        check("a5_busy_first", 32'(o_busy), 32'd1);
        wait_to(n + T);
        check("a5_start_last", 32'(o_dout), 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_to(n + 1 + (k + 1) * T + T / 2);
            check("a5_bit", 32'(o_dout), 32'(a5_bits[k]));
        end
        wait_to(n + 1 + 9 * T + T / 2);
        check("a5_stop", 32'(o_dout), 32'd1);
        wait_to(n + FRAME);
        check("a5_done_early", 32'(o_done), 32'd0);
        wait_to(n + 321);
        check("a5_done", 32'(o_done), 32'd1);
        check("a5_done_busy", 32'(o_busy), 32'd1);
        wait_to(n + 322);
        check("a5_idle_busy", 32'(o_busy), 32'd0);
        check("a5_idle_done", 32'(o_done), 32'd0);
        wait_idle();
        expect_rx("a5_rx", 8'hA5);

        // Loopback bytes, one done pulse each
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            send_byte(lb_bytes[i], n);
            wait_idle();
            expect_rx("lb_rx", lb_bytes[i]);
            check("lb_done_count", done_cnt - d0, 32'd1);
        end

        // Back-to-back with i_send held; data changed after first accept
        d0       = done_cnt;
        i_txdata = 8'h3C;
        i_send   = 1'b1;
        n        = cyc;
        tick();
        i_txdata = 8'hC3;
        wait_to(n + 322);
        check("b2b_gap_dout", 32'(o_dout), 32'd1);
        check("b2b_gap_busy", 32'(o_busy), 32'd0);
        tick();
        check("b2b_second_start", 32'(o_dout), 32'd0);
        i_send = 1'b0;
        wait_idle();
        expect_rx("b2b_rx0", 8'h3C);
        expect_rx("b2b_rx1", 8'hC3);
        check("b2b_done_count", done_cnt - d0, 32'd2);

        // Request while busy, and request with enable low
        send_byte(8'h5A, n);
        wait_to(n + 100);
        i_txdata = 8'hFF;
        i_send   = 1'b1;
        tick();
        i_send = 1'b0;
        wait_idle();
        expect_rx("busyreq_rx", 8'h5A);
        check("busyreq_no_extra", rxq.size(), 32'd0);
        i_enable = 1'b0;
        i_send   = 1'b1;
        repeat (5) tick();
        check("noen_busy", 32'(o_busy), 32'd0);
        check("noen_dout", 32'(o_dout), 32'd1);
        i_send   = 1'b0;
        i_enable = 1'b1;
        tick();

        // Enable dropped mid-frame
        send_byte(8'hE7, n);
        wait_to(n + 50);
        i_enable = 1'b0;
        wait_to(n + 321);
        check("endrop_done", 32'(o_done), 32'd1);
        i_enable = 1'b1;
        wait_idle();
        expect_rx("endrop_rx", 8'hE7);

        // Reset in the middle of the data bits
        d0 = done_cnt;
        send_byte(8'h96, n);
        wait_to(n + 150);
        i_rst   = 1'b1;
        rx_busy = 1'b0;
        tick();
        i_rst = 1'b0;
        check("midrst_dout", 32'(o_dout), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        repeat (400) tick();
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_no_byte", rxq.size(), 32'd0);
        send_byte(8'h96, n);
        wait_idle();
        expect_rx("postrst_rx", 8'h96);
        check("postrst_done", done_cnt - d0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
